// File: rtl/iob_timer_mc_core.sv
// Multi-channel timer core: N_CH independent up-counters sharing one prescaler,
// each with compare, free-run/one-shot/periodic modes, sticky irq and snapshot.

module iob_timer_mc_ch #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_cmp,
    input  logic             i_clr,
    input  logic             i_sample,
    input  logic             i_ack,
    output logic [CNT_W-1:0] o_value,
    output logic             o_running,
    output logic             o_irq
);

    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_FREE_ALT = 2'b11
    } mode_e;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_value;
    logic             r_running;
    logic             r_irq;
    logic             r_en_d;

    mode_e            w_mode;
    logic             w_counting;
    logic             w_match;
    logic             w_rise;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_run_nxt;
    logic             w_irq_nxt;

    always_comb begin
        w_mode     = mode_e'(i_mode);
        w_counting = i_en & r_running;
        // A clear pulse suppresses the match event for that cycle.
        w_match    = i_tick & w_counting & (r_cnt == i_cmp) & ~i_clr;
        w_rise     = i_en & ~r_en_d;

        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_tick && w_counting) begin
            if (w_match && w_mode == MODE_ONESHOT) begin
                w_cnt_nxt = r_cnt;
            end else if (w_match && w_mode == MODE_PERIODIC) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        w_run_nxt = r_running;
        if (i_clr) begin
            w_run_nxt = 1'b1;
        end else if (w_match && w_mode == MODE_ONESHOT) begin
            w_run_nxt = 1'b0;
        end else if (w_rise) begin
            w_run_nxt = 1'b1;
        end

        w_irq_nxt = r_irq;
        if (w_match) begin
            w_irq_nxt = 1'b1;
        end else if (i_ack) begin
            w_irq_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt     <= '0;
            r_value   <= '0;
            r_running <= 1'b1;
            r_irq     <= 1'b0;
            r_en_d    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_running <= w_run_nxt;
            r_irq     <= w_irq_nxt;
            r_en_d    <= i_en;
            if (i_sample) begin
                r_value <= r_cnt;
            end
        end
    end

    assign o_value   = r_value;
    assign o_running = r_running;
    assign o_irq     = r_irq;

endmodule

module iob_timer_mc_core #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PRESC_W-1:0]    i_presc,
    input  logic [N_CH-1:0]       i_ch_en,
    input  logic [2*N_CH-1:0]     i_ch_mode,
    input  logic [N_CH*CNT_W-1:0] i_ch_cmp,
    input  logic [N_CH-1:0]       i_ch_clr,
    input  logic [N_CH-1:0]       i_ch_sample,
    input  logic [N_CH-1:0]       i_irq_ack,
    output logic [N_CH*CNT_W-1:0] o_ch_value,
    output logic [N_CH-1:0]       o_ch_running,
    output logic [N_CH-1:0]       o_irq,
    output logic                  o_irq_any
);

    logic [PRESC_W-1:0] r_pcnt;
    logic               w_tick;

    // >= rather than == so that lowering presc mid-count wraps immediately.
    assign w_tick = (r_pcnt >= i_presc);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        iob_timer_mc_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_en      (i_ch_en[g]),
            .i_mode    (i_ch_mode[2*g +: 2]),
            .i_cmp     (i_ch_cmp[g*CNT_W +: CNT_W]),
            .i_clr     (i_ch_clr[g]),
            .i_sample  (i_ch_sample[g]),
            .i_ack     (i_irq_ack[g]),
            .o_value   (o_ch_value[g*CNT_W +: CNT_W]),
            .o_running (o_ch_running[g]),
            .o_irq     (o_irq[g])
        );
    end

    assign o_irq_any = |o_irq;

endmodule
